// File: rtl/saturn_pkg.sv
// Shared types for the Saturn instruction fetch front end.
package saturn_pkg;
    localparam int ADDR_W = 20;

    typedef logic [3:0] nibble_t;

    typedef enum logic [1:0] {
        F_IDLE    = 2'd0,
        F_FETCH   = 2'd1,
        F_DISCARD = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/saturn_nibble_fetch_if.sv
// Memory-port and decoder-side signals of the nibble fetch unit.
interface saturn_nibble_fetch_if
    import saturn_pkg::*;
#(
    parameter int ADDR_W = saturn_pkg::ADDR_W
);
    logic              o_mem_req;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              i_mem_ack;
    nibble_t           i_mem_nibble;
    nibble_t           o_nibble;
    logic              o_en_dec;
    logic [ADDR_W-1:0] o_pc;
    logic              i_dec_stall;
    logic              i_load_pc;
    logic [ADDR_W-1:0] i_new_pc;

    modport master (
        output o_mem_req, o_mem_addr, o_nibble, o_en_dec, o_pc,
        input  i_mem_ack, i_mem_nibble, i_dec_stall, i_load_pc, i_new_pc
    );

    modport slave (
        input  o_mem_req, o_mem_addr, o_nibble, o_en_dec, o_pc,
        output i_mem_ack, i_mem_nibble, i_dec_stall, i_load_pc, i_new_pc
    );
endinterface

// File: rtl/saturn_nibble_fifo.sv
// Prefetch queue of {address, nibble} pairs; head is read straight from flops.
module saturn_nibble_fifo
    import saturn_pkg::*;
#(
    parameter int ADDR_W = saturn_pkg::ADDR_W,
    parameter int DEPTH  = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  nibble_t           push_nib_i,
    input  logic              pop_i,
    output logic [ADDR_W-1:0] head_addr_o,
    output nibble_t           head_nib_o,
    output logic              empty_o,
    output logic [PW:0]       count_o
);
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
    nibble_t [DEPTH-1:0]          nib_q;
    logic [PW-1:0]                wr_ptr_q, rd_ptr_q;
    logic [PW:0]                  count_q;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            nib_q[wr_ptr_q]  <= push_nib_i;
        end
    end

    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign head_addr_o = empty_o ? '0 : addr_q[rd_ptr_q];
    assign head_nib_o  = empty_o ? '0 : nib_q[rd_ptr_q];
endmodule

// File: rtl/saturn_nibble_fetch.sv
// Fetch PC, single-outstanding memory request FSM and prefetch queue feeding the decoder.
module saturn_nibble_fetch
    import saturn_pkg::*;
#(
    parameter int ADDR_W = saturn_pkg::ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [31:0]           i_cycles,
    saturn_nibble_fetch_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] redir_q, redir_d;

    logic          push, pop, empty;
    logic [CW-1:0] count;
    logic [CW:0]   cnt_pop, cnt_push;
    logic          unused_cycles;

    assign unused_cycles = ^i_cycles;

    assign pop      = ~empty & ~bus.i_dec_stall & ~bus.i_load_pc;
    assign cnt_pop  = {1'b0, count} - {{CW{1'b0}}, pop};
    assign cnt_push = cnt_pop + {{CW{1'b0}}, 1'b1};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= F_IDLE;
            fetch_addr_q <= '0;
            redir_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            redir_q      <= redir_d;
        end
    end

    // fetch_addr_q doubles as the request address, so it only moves on ack or from IDLE.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        redir_d      = redir_q;
        push         = 1'b0;
        unique case (state_q)
            F_IDLE: begin
                if (bus.i_load_pc) begin
                    fetch_addr_d = bus.i_new_pc;
                    state_d      = F_FETCH;
                end else if (cnt_pop < (CW+1)'(DEPTH)) begin
                    state_d = F_FETCH;
                end
            end
            F_FETCH: begin
                if (bus.i_load_pc) begin
                    if (bus.i_mem_ack) begin
                        fetch_addr_d = bus.i_new_pc;
                    end else begin
                        redir_d = bus.i_new_pc;
                        state_d = F_DISCARD;
                    end
                end else if (bus.i_mem_ack) begin
                    push         = 1'b1;
                    fetch_addr_d = fetch_addr_q + 1'b1;
                    if (!(cnt_push < (CW+1)'(DEPTH))) state_d = F_IDLE;
                end
            end
            F_DISCARD: begin
                if (bus.i_load_pc) redir_d = bus.i_new_pc;
                if (bus.i_mem_ack) begin
                    fetch_addr_d = bus.i_load_pc ? bus.i_new_pc : redir_q;
                    state_d      = F_FETCH;
                end
            end
            default: state_d = F_IDLE;
        endcase
    end

    assign bus.o_mem_req  = (state_q != F_IDLE);
    assign bus.o_mem_addr = fetch_addr_q;
    assign bus.o_en_dec   = pop;

    saturn_nibble_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i       (i_clk),
        .rst_i       (i_reset),
        .flush_i     (bus.i_load_pc),
        .push_i      (push),
        .push_addr_i (fetch_addr_q),
        .push_nib_i  (bus.i_mem_nibble),
        .pop_i       (pop),
        .head_addr_o (bus.o_pc),
        .head_nib_o  (bus.o_nibble),
        .empty_o     (empty),
        .count_o     (count)
    );
endmodule

// File: tb/tb_saturn_nibble_fetch.sv
// Directed bench for saturn_nibble_fetch with hand-computed expectations.
module tb_saturn_nibble_fetch;
    import saturn_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cycles = '0;
    logic        auto_ack = 1'b0;
    logic        man_ack = 1'b0;
    logic [3:0]  man_nib = '0;
    int          n_cmp = 0;
    int          n_fail = 0;

    saturn_nibble_fetch_if #(.ADDR_W(20)) bus ();

    saturn_nibble_fetch #(.ADDR_W(20), .DEPTH(4)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_cycles (cycles),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycles <= cycles + 1;

    // Auto mode: memory answers every request in the same cycle with addr[3:0].
    assign bus.i_mem_ack    = auto_ack ? bus.o_mem_req : man_ack;
    assign bus.i_mem_nibble = auto_ack ? bus.o_mem_addr[3:0] : man_nib;

    task automatic nxt();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic restart(input logic stall);
        @(negedge clk);
        rst = 1'b1;
        auto_ack = 1'b1;
        man_ack = 1'b0;
        bus.i_dec_stall = stall;
        bus.i_load_pc = 1'b0;
        bus.i_new_pc = '0;
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_dec_stall = 1'b0;
        bus.i_load_pc = 1'b0;
        bus.i_new_pc = '0;
        auto_ack = 1'b1;
        #3;
        n_cmp++; if (bus.o_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", bus.o_mem_req); end
        n_cmp++; if (bus.o_mem_addr !== 20'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", bus.o_mem_addr); end
        n_cmp++; if (bus.o_en_dec !== 1'b0 || bus.o_nibble !== 4'h0 || bus.o_pc !== 20'h0) begin
            n_fail++; $display("FAIL reset_dec got en=%b nib=%h pc=%h want 0/0/0", bus.o_en_dec, bus.o_nibble, bus.o_pc); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.o_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_idle got %b want 0", bus.o_mem_req); end
        nxt(); #1;
        n_cmp++; if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 20'h0 || bus.o_en_dec !== 1'b0) begin
            n_fail++; $display("FAIL first_req got req=%b addr=%h en=%b want 1/0/0", bus.o_mem_req, bus.o_mem_addr, bus.o_en_dec); end
    endtask

    task automatic test_stream();
        restart(1'b0);
        nxt(); #1;
        n_cmp++; if (bus.o_en_dec !== 1'b0) begin n_fail++; $display("FAIL stream_c1 got en=%b want 0", bus.o_en_dec); end
        for (int k = 0; k < 16; k++) begin
            nxt(); #1;
            n_cmp++;
            if (bus.o_en_dec !== 1'b1 || bus.o_pc !== 20'(k) || bus.o_nibble !== 4'(k)) begin
                n_fail++; $display("FAIL stream[%0d] got en=%b pc=%h nib=%h want 1/%h/%h", k, bus.o_en_dec, bus.o_pc, bus.o_nibble, 20'(k), 4'(k)); end
        end
    endtask

    task automatic test_stall();
        int acks = 0;
        restart(1'b1);
        for (int c = 0; c < 10; c++) begin
            nxt(); #1;
            if (bus.o_mem_req && bus.i_mem_ack) acks++;
            n_cmp++; if (bus.o_en_dec !== 1'b0) begin n_fail++; $display("FAIL stall_en[%0d] got %b want 0", c, bus.o_en_dec); end
        end
        n_cmp++; if (acks !== 4) begin n_fail++; $display("FAIL stall_acks got %0d want 4", acks); end
        n_cmp++; if (bus.o_mem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req got %b want 0", bus.o_mem_req); end
        bus.i_dec_stall = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) nxt();
            #1;
            n_cmp++;
            if (bus.o_en_dec !== 1'b1 || bus.o_pc !== 20'(k) || bus.o_nibble !== 4'(k)) begin
                n_fail++; $display("FAIL drain[%0d] got en=%b pc=%h nib=%h want 1/%h/%h", k, bus.o_en_dec, bus.o_pc, bus.o_nibble, 20'(k), 4'(k)); end
        end
    endtask

    task automatic test_redirect();
        restart(1'b0);
        nxt(); nxt(); nxt(); nxt();
        auto_ack = 1'b0;
        bus.i_load_pc = 1'b1;
        bus.i_new_pc = 20'h12345;
        #1;
        n_cmp++; if (bus.o_en_dec !== 1'b0 || bus.o_mem_addr !== 20'h3 || bus.o_mem_req !== 1'b1) begin
            n_fail++; $display("FAIL redir_load got en=%b addr=%h req=%b want 0/00003/1", bus.o_en_dec, bus.o_mem_addr, bus.o_mem_req); end
        nxt();
        bus.i_load_pc = 1'b0;
        #1;
        n_cmp++; if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 20'h3 || bus.o_en_dec !== 1'b0) begin
            n_fail++; $display("FAIL redir_hold got req=%b addr=%h en=%b want 1/00003/0", bus.o_mem_req, bus.o_mem_addr, bus.o_en_dec); end
        nxt();
        man_ack = 1'b1;
        man_nib = 4'hA;
        #1;
        n_cmp++; if (bus.o_en_dec !== 1'b0 || bus.o_mem_addr !== 20'h3) begin
            n_fail++; $display("FAIL redir_wait got en=%b addr=%h want 0/00003", bus.o_en_dec, bus.o_mem_addr); end
        nxt();
        man_ack = 1'b0;
        #1;
        n_cmp++; if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 20'h12345 || bus.o_en_dec !== 1'b0) begin
            n_fail++; $display("FAIL redir_new got req=%b addr=%h en=%b want 1/12345/0", bus.o_mem_req, bus.o_mem_addr, bus.o_en_dec); end
        man_ack = 1'b1;
        man_nib = 4'h5;
        nxt();
        man_ack = 1'b0;
        #1;
        n_cmp++; if (bus.o_en_dec !== 1'b1 || bus.o_pc !== 20'h12345 || bus.o_nibble !== 4'h5) begin
            n_fail++; $display("FAIL redir_first got en=%b pc=%h nib=%h want 1/12345/5", bus.o_en_dec, bus.o_pc, bus.o_nibble); end
    endtask

    task automatic test_wrap();
        logic [19:0] exp_pc [4];
        exp_pc[0] = 20'hFFFFE; exp_pc[1] = 20'hFFFFF; exp_pc[2] = 20'h00000; exp_pc[3] = 20'h00001;
        restart(1'b0);
        nxt(); nxt(); nxt();
        bus.i_load_pc = 1'b1;
        bus.i_new_pc = 20'hFFFFE;
        #1;
        n_cmp++; if (bus.o_en_dec !== 1'b0) begin n_fail++; $display("FAIL wrap_load got en=%b want 0", bus.o_en_dec); end
        nxt();
        bus.i_load_pc = 1'b0;
        #1;
        n_cmp++; if (bus.o_en_dec !== 1'b0 || bus.o_mem_addr !== 20'hFFFFE) begin
            n_fail++; $display("FAIL wrap_req got en=%b addr=%h want 0/FFFFE", bus.o_en_dec, bus.o_mem_addr); end
        for (int k = 0; k < 4; k++) begin
            nxt(); #1;
            n_cmp++;
            if (bus.o_en_dec !== 1'b1 || bus.o_pc !== exp_pc[k] || bus.o_nibble !== exp_pc[k][3:0]) begin
                n_fail++; $display("FAIL wrap[%0d] got en=%b pc=%h nib=%h want 1/%h/%h", k, bus.o_en_dec, bus.o_pc, bus.o_nibble, exp_pc[k], exp_pc[k][3:0]); end
        end
    endtask

    task automatic test_async_reset();
        restart(1'b1);
        nxt(); nxt(); nxt(); nxt();
        auto_ack = 1'b0;
        bus.i_dec_stall = 1'b0;
        #1;
        n_cmp++; if (bus.o_en_dec !== 1'b1 || bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 20'h3) begin
            n_fail++; $display("FAIL arst_pre got en=%b req=%b addr=%h want 1/1/00003", bus.o_en_dec, bus.o_mem_req, bus.o_mem_addr); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (bus.o_mem_req !== 1'b0 || bus.o_mem_addr !== 20'h0 || bus.o_en_dec !== 1'b0 || bus.o_nibble !== 4'h0 || bus.o_pc !== 20'h0) begin
            n_fail++; $display("FAIL arst_now got req=%b addr=%h en=%b nib=%h pc=%h want all 0", bus.o_mem_req, bus.o_mem_addr, bus.o_en_dec, bus.o_nibble, bus.o_pc); end
        nxt();
        rst = 1'b0;
        man_ack = 1'b1;
        man_nib = 4'h9;
        #1;
        n_cmp++; if (bus.o_mem_req !== 1'b0) begin n_fail++; $display("FAIL arst_idle got req=%b want 0", bus.o_mem_req); end
        nxt();
        man_ack = 1'b0;
        #1;
        n_cmp++; if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 20'h0 || bus.o_en_dec !== 1'b0) begin
            n_fail++; $display("FAIL arst_stray got req=%b addr=%h en=%b want 1/00000/0", bus.o_mem_req, bus.o_mem_addr, bus.o_en_dec); end
        man_ack = 1'b1;
        man_nib = 4'h7;
        nxt();
        man_ack = 1'b0;
        #1;
        n_cmp++; if (bus.o_en_dec !== 1'b1 || bus.o_pc !== 20'h0 || bus.o_nibble !== 4'h7) begin
            n_fail++; $display("FAIL arst_restart got en=%b pc=%h nib=%h want 1/00000/7", bus.o_en_dec, bus.o_pc, bus.o_nibble); end
    endtask

    task automatic test_full_minus_one();
        restart(1'b1);
        nxt(); nxt(); nxt(); nxt();
        bus.i_dec_stall = 1'b0;
        #1;
        n_cmp++; if (bus.o_en_dec !== 1'b1 || bus.o_pc !== 20'h0 || bus.o_mem_addr !== 20'h3 || bus.i_mem_ack !== 1'b1) begin
            n_fail++; $display("FAIL fm1_pre got en=%b pc=%h addr=%h ack=%b want 1/00000/00003/1", bus.o_en_dec, bus.o_pc, bus.o_mem_addr, bus.i_mem_ack); end
        nxt(); #1;
        n_cmp++; if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 20'h4 || bus.o_pc !== 20'h1 || bus.o_en_dec !== 1'b1) begin
            n_fail++; $display("FAIL fm1_post got req=%b addr=%h pc=%h en=%b want 1/00004/00001/1", bus.o_mem_req, bus.o_mem_addr, bus.o_pc, bus.o_en_dec); end
        nxt(); #1;
        n_cmp++; if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 20'h5 || bus.o_pc !== 20'h2) begin
            n_fail++; $display("FAIL fm1_steady got req=%b addr=%h pc=%h want 1/00005/00002", bus.o_mem_req, bus.o_mem_addr, bus.o_pc); end
        nxt();
        bus.i_dec_stall = 1'b1;
        #1;
        n_cmp++; if (bus.o_en_dec !== 1'b0 || bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 20'h6) begin
            n_fail++; $display("FAIL fm1_stall got en=%b req=%b addr=%h want 0/1/00006", bus.o_en_dec, bus.o_mem_req, bus.o_mem_addr); end
        nxt(); #1;
        n_cmp++; if (bus.o_mem_req !== 1'b0) begin n_fail++; $display("FAIL fm1_full got req=%b want 0", bus.o_mem_req); end
        bus.i_dec_stall = 1'b0;
        for (int k = 3; k < 9; k++) begin
            if (k > 3) nxt();
            #1;
            n_cmp++;
            if (bus.o_en_dec !== 1'b1 || bus.o_pc !== 20'(k) || bus.o_nibble !== 4'(k)) begin
                n_fail++; $display("FAIL fm1_drain[%0d] got en=%b pc=%h nib=%h want 1/%h/%h", k, bus.o_en_dec, bus.o_pc, bus.o_nibble, 20'(k), 4'(k)); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_async_reset();
        test_full_minus_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
